mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit, directly downstream of the EX/MEM pipeline register; consumes its outputs and produces the write-back payload for the MEM/WB register.
- Issues one data-memory transaction per load/store over a req/gnt + rvalid bus, and holds the pipeline (stall_o) while the access is in flight.
- Provides byte-lane steering for stores, sign/zero extension for loads, misalignment detection and a response-timeout guard.

Parameters:
- TIMEOUT_CYCLES, 16: maximum number of cycles in REQ or RESP before the access is aborted; 0 disables the timeout.
- RESET_ADDR_VAL, 32'h0: reset value of dmem_addr_o.

Ports:
- clk  in  1  single clock; all state on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_plus4_i  in  32  return address, selected for write-back when data_dest_i=2'b10.
- alu_result_i  in  32  ALU result; also the effective memory address.
- rs2_i  in  32  store data.
- data_dest_i  in  2  write-back source: 00=ALU, 01=load data, 10=pc_plus4, 11=ALU.
- lsu_op_i  in  3  access type, RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are treated as W.
- reg_wr_addr_i  in  5  destination register.
- reg_wr_sig_i  in  1  register write enable.
- mem_wr_sig_i  in  1  store request.
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  1=write, 0=read.
- dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  lane-steered write data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  32  read data.
- wb_data_o  out  32  write-back data.
- reg_wr_addr_o  out  5  passthrough of reg_wr_addr_i.
- reg_wr_sig_o  out  1  qualified register write enable.
- stall_o  out  1  hold the upstream stages and EX/MEM.
- misaligned_o  out  1  one-cycle pulse: misaligned access.
- bus_err_o  out  1  one-cycle pulse: timeout abort.

Behaviour:
- Access kinds: load = data_dest_i==01 && !mem_wr_sig_i; store = mem_wr_sig_i; anything else = no access.
- No access: zero latency, stall_o=0. wb_data_o is muxed from data_dest_i; reg_wr_sig_o=reg_wr_sig_i.
- Misaligned access: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - No bus request is made; misaligned_o=1 in the same cycle; stall_o=0; reg_wr_sig_o=0.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - On an aligned access: register addr/be/wdata/we and the op, set stall_o=1 combinationally, next state REQ.
- REQ:
  - dmem_req_o=1; stall_o=1.
  - On gnt: a store goes to DONE; a load goes to RESP.
  - If gnt and rvalid arrive in the same cycle for a load, capture the data and go to DONE.
- RESP:
  - stall_o=1.
  - On rvalid: capture the extended load data into a register, go to DONE.
- DONE:
  - stall_o=0; wb_data_o=captured load data (loads) or the muxed value (stores).
  - reg_wr_sig_o=reg_wr_sig_i.
  - Next state IDLE. IDLE therefore always sees a new instruction, so there is no double issue.
- Store lanes:
  - B: be=1<<addr[1:0], wdata={4{rs2[7:0]}}.
  - H: be=addr[1]?1100:0011, wdata={2{rs2[15:0]}}.
  - W: be=1111, wdata=rs2.
- Load extraction: select the byte or halfword by addr[1:0]; sign-extend for B/H, zero-extend for BU/HU.
- Timeout:
  - Counter cleared on entering REQ, increments every cycle in REQ/RESP.
  - When it reaches TIMEOUT_CYCLES without completion: bus_err_o=1 for one cycle, dmem_req_o drops, go to DONE with reg_wr_sig_o=0.
  - A late rvalid in IDLE is ignored.
- Outputs outside REQ: dmem_req_o=0, dmem_we_o=0.
- Reset (asynchronous, any state): state=IDLE, counter=0, captured data=0, dmem_addr_o=RESET_ADDR_VAL, dmem_be_o=0, dmem_wdata_o=0, dmem_req_o=0, stall_o=0, misaligned_o=0, bus_err_o=0.
  - Combinational passthroughs follow their inputs.
  - An outstanding request is abandoned immediately.
- Latency, zero-wait bus (gnt in first REQ cycle, rvalid the next cycle): store stalls 2 cycles, load stalls 3 cycles.

Test Plan:
- ALU op (data_dest=00, alu_result=0x1234) -> wb_data_o=0x1234, stall_o=0, dmem_req_o never asserted.
- SB rs2=0xAABBCCDD, addr=0x103, gnt immediate -> dmem_be_o=1000, wdata=0xDDDDDDDD, addr=0x100, stall 2 cycles.
- LB addr=0x101, rdata=0x0000_8000 -> wb_data_o=0xFFFFFF80; the same access as LBU -> 0x00000080; LHU addr=0x102, rdata=0xBEEF0000 -> 0x0000BEEF.
- LW addr=0x102 -> misaligned_o pulse, no dmem_req_o, reg_wr_sig_o=0, stall_o=0.
- LW with gnt held low 16 cycles (TIMEOUT_CYCLES=16) -> bus_err_o pulse, req drops, reg_wr_sig_o=0 in DONE, then IDLE.
- Reset asserted while in RESP -> dmem_req_o/stall_o=0 immediately; after release, a new LW completes normally.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the memory-stage LSU (master) and the data memory (slave).
// Signal names carry the direction as seen from the LSU.
interface mem_stage_lsu_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues one req/gnt + rvalid transaction per load/store,
// stalls the pipeline while it is in flight and forms the write-back payload.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] RESET_ADDR_VAL = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           pc_plus4_i,
  input  logic [31:0]           alu_result_i,
  input  logic [31:0]           rs2_i,
  input  logic [1:0]            data_dest_i,
  input  logic [2:0]            lsu_op_i,
  input  logic [4:0]            reg_wr_addr_i,
  input  logic                  reg_wr_sig_i,
  input  logic                  mem_wr_sig_i,
  mem_stage_lsu_if.master       dmem,
  output logic [31:0]           wb_data_o,
  output logic [4:0]            reg_wr_addr_o,
  output logic                  reg_wr_sig_o,
  output logic                  stall_o,
  output logic                  misaligned_o,
  output logic                  bus_err_o
);

  // Counter only needs to reach TIMEOUT_CYCLES-1; the abort happens on that cycle.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP, ST_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_rdata;
  logic             r_load;
  logic             r_timeout;
  logic             r_uns;
  logic             r_size_b;
  logic             r_size_h;
  logic [1:0]       r_off;
  logic             r_req;
  logic             r_we;
  logic             r_bus_err;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_be;

  logic             w_is_store;
  logic             w_is_load;
  logic             w_access;
  logic             w_size_b;
  logic             w_size_h;
  logic             w_misaligned;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [31:0]      w_wb_mux;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_load_ext;
  logic             w_timeout_hit;

  assign w_is_store = mem_wr_sig_i;
  assign w_is_load  = (data_dest_i == 2'b01) && !mem_wr_sig_i;
  assign w_access   = w_is_store || w_is_load;
  assign w_wb_mux   = (data_dest_i == 2'b10) ? pc_plus4_i : alu_result_i;
  assign w_timeout_hit = TO_EN && (r_cnt == CNT_LAST);

  // Access size; unlisted funct3 codes fall through to word.
  always_comb begin
    w_size_b = 1'b0;
    w_size_h = 1'b0;
    case (lsu_op_i)
      3'b000, 3'b100: w_size_b = 1'b1;
      3'b001, 3'b101: w_size_h = 1'b1;
      default: ;
    endcase
  end

  assign w_misaligned = (w_size_h && alu_result_i[0]) ||
                        (!w_size_b && !w_size_h && (alu_result_i[1:0] != 2'b00));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = rs2_i;
    if (w_size_b) begin
      w_be    = 4'b0001 << alu_result_i[1:0];
      w_wdata = {4{rs2_i[7:0]}};
    end else if (w_size_h) begin
      w_be    = alu_result_i[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{rs2_i[15:0]}};
    end
  end

  // Lane extraction uses the offset/op latched at issue, not the live inputs.
  always_comb begin
    w_byte = dmem.dmem_rdata_i[7:0];
    case (r_off)
      2'd1:    w_byte = dmem.dmem_rdata_i[15:8];
      2'd2:    w_byte = dmem.dmem_rdata_i[23:16];
      2'd3:    w_byte = dmem.dmem_rdata_i[31:24];
      default: w_byte = dmem.dmem_rdata_i[7:0];
    endcase
    w_half = r_off[1] ? dmem.dmem_rdata_i[31:16] : dmem.dmem_rdata_i[15:0];
    if (r_size_b) begin
      w_load_ext = {{24{w_byte[7] & ~r_uns}}, w_byte};
    end else if (r_size_h) begin
      w_load_ext = {{16{w_half[15] & ~r_uns}}, w_half};
    end else begin
      w_load_ext = dmem.dmem_rdata_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_rdata   <= 32'h0;
      r_load    <= 1'b0;
      r_timeout <= 1'b0;
      r_uns     <= 1'b0;
      r_size_b  <= 1'b0;
      r_size_h  <= 1'b0;
      r_off     <= 2'b00;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_bus_err <= 1'b0;
      r_addr    <= RESET_ADDR_VAL;
      r_be      <= 4'b0000;
      r_wdata   <= 32'h0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_access && !w_misaligned) begin
            r_addr    <= {alu_result_i[31:2], 2'b00};
            r_be      <= w_be;
            r_wdata   <= w_wdata;
            r_we      <= w_is_store;
            r_req     <= 1'b1;
            r_load    <= w_is_load;
            r_off     <= alu_result_i[1:0];
            r_size_b  <= w_size_b;
            r_size_h  <= w_size_h;
            r_uns     <= lsu_op_i[2];
            r_timeout <= 1'b0;
            r_cnt     <= '0;
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (dmem.dmem_gnt_i) begin
            r_req <= 1'b0;
            r_we  <= 1'b0;
            if (!r_load) begin
              r_state <= ST_DONE;
            end else if (dmem.dmem_rvalid_i) begin
              r_rdata <= w_load_ext;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_RESP;
            end
          end else if (w_timeout_hit) begin
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_bus_err <= 1'b1;
            r_timeout <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_RESP: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (dmem.dmem_rvalid_i) begin
            r_rdata <= w_load_ext;
            r_state <= ST_DONE;
          end else if (w_timeout_hit) begin
            r_bus_err <= 1'b1;
            r_timeout <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dmem.dmem_req_o   = r_req;
  assign dmem.dmem_we_o    = r_we;
  assign dmem.dmem_addr_o  = r_addr;
  assign dmem.dmem_be_o    = r_be;
  assign dmem.dmem_wdata_o = r_wdata;
  assign bus_err_o         = r_bus_err;
  assign reg_wr_addr_o     = reg_wr_addr_i;

  // Stall and the misalignment flag react to the incoming instruction in the same cycle.
  always_comb begin
    stall_o      = 1'b0;
    misaligned_o = 1'b0;
    reg_wr_sig_o = 1'b0;
    wb_data_o    = w_wb_mux;
    case (r_state)
      ST_IDLE: begin
        if (!w_access) begin
          reg_wr_sig_o = reg_wr_sig_i;
        end else if (w_misaligned) begin
          misaligned_o = ~reset;
        end else begin
          stall_o = ~reset;
        end
      end
      ST_REQ, ST_RESP: stall_o = ~reset;
      ST_DONE: begin
        reg_wr_sig_o = reg_wr_sig_i & ~r_timeout;
        if (r_load) wb_data_o = r_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a bus responder with programmable grant/rvalid
// latency plus a scoreboard of expected write-back results per instruction.
module tb_mem_stage_lsu;

  localparam int unsigned TO    = 16;
  localparam logic [31:0] RADDR = 32'hCAFE_0000;
  localparam int          NEVER = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_plus4_i = 32'h0;
  logic [31:0] alu_result_i = 32'h0;
  logic [31:0] rs2_i = 32'h0;
  logic [1:0]  data_dest_i = 2'b00;
  logic [2:0]  lsu_op_i = 3'b000;
  logic [4:0]  reg_wr_addr_i = 5'd0;
  logic        reg_wr_sig_i = 1'b0;
  logic        mem_wr_sig_i = 1'b0;
  logic [31:0] wb_data_o;
  logic [4:0]  reg_wr_addr_o;
  logic        reg_wr_sig_o;
  logic        stall_o;
  logic        misaligned_o;
  logic        bus_err_o;

  mem_stage_lsu_if dmem_if ();

  mem_stage_lsu #(.TIMEOUT_CYCLES(TO), .RESET_ADDR_VAL(RADDR)) dut (
    .clk(clk), .reset(reset),
    .pc_plus4_i(pc_plus4_i), .alu_result_i(alu_result_i), .rs2_i(rs2_i),
    .data_dest_i(data_dest_i), .lsu_op_i(lsu_op_i),
    .reg_wr_addr_i(reg_wr_addr_i), .reg_wr_sig_i(reg_wr_sig_i), .mem_wr_sig_i(mem_wr_sig_i),
    .dmem(dmem_if.master),
    .wb_data_o(wb_data_o), .reg_wr_addr_o(reg_wr_addr_o), .reg_wr_sig_o(reg_wr_sig_o),
    .stall_o(stall_o), .misaligned_o(misaligned_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Responder configuration, only changed while the DUT is idle.
  int          gnt_wait = 0;
  int          rv_lat = 1;
  logic [31:0] rdata_val = 32'h0;
  int          req_age = 0;
  int          rv_wait = -1;

  always @(negedge clk) begin
    dmem_if.dmem_gnt_i    = 1'b0;
    dmem_if.dmem_rvalid_i = 1'b0;
    dmem_if.dmem_rdata_i  = rdata_val;
    if (reset) begin
      req_age = 0;
      rv_wait = -1;
    end else begin
      if (rv_wait == 0) begin
        dmem_if.dmem_rvalid_i = 1'b1;
        rv_wait = -1;
      end else if (rv_wait > 0) begin
        rv_wait--;
      end
      if (dmem_if.dmem_req_o) begin
        if (req_age == gnt_wait) begin
          dmem_if.dmem_gnt_i = 1'b1;
          req_age = 0;
          if (!dmem_if.dmem_we_o) begin
            if (rv_lat == 0) dmem_if.dmem_rvalid_i = 1'b1;
            else if (rv_lat < NEVER) rv_wait = rv_lat - 1;
          end
        end else begin
          req_age++;
        end
      end else begin
        req_age = 0;
      end
    end
  end

  typedef struct {
    logic [31:0] wb;
    logic        chk_wb;
    logic        rwr;
    logic [4:0]  rd;
    int          stalls;
    int          reqs;
    logic        mis;
    logic        berr;
    logic        chk_bus;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ld_model(logic [31:0] rd, logic [1:0] off, logic [2:0] op);
    logic [31:0] sh;
    sh = rd >> (8 * off);
    case (op)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  // Drive one instruction, push its expected outcome, then follow it to completion.
  task automatic step(input string tag, input logic [31:0] pc, input logic [31:0] alu,
                      input logic [31:0] rs2, input logic [1:0] dest, input logic [2:0] op,
                      input logic rwr, input logic mwr);
    exp_t e;
    exp_t got;
    logic is_b, is_h, is_load, access, mis, to_mode;
    int   st, reqs;
    logic mis_seen, bus_cap, cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;

    is_b    = (op == 3'b000) || (op == 3'b100);
    is_h    = (op == 3'b001) || (op == 3'b101);
    is_load = (dest == 2'b01) && !mwr;
    access  = mwr || is_load;
    mis     = (is_h && alu[0]) || (!is_b && !is_h && (alu[1:0] != 2'b00));
    to_mode = (gnt_wait >= NEVER) || (is_load && rv_lat >= NEVER);

    e.wb      = (dest == 2'b10) ? pc : alu;
    e.chk_wb  = 1'b1;
    e.rwr     = rwr;
    e.rd      = alu[4:0] ^ 5'h15;
    e.stalls  = 0;
    e.reqs    = 0;
    e.mis     = 1'b0;
    e.berr    = 1'b0;
    e.chk_bus = 1'b0;
    e.we      = mwr;
    e.addr    = {alu[31:2], 2'b00};
    e.be      = is_b ? (4'b0001 << alu[1:0]) : is_h ? (4'b0011 << alu[1:0]) : 4'b1111;
    e.wdata   = is_b ? {4{rs2[7:0]}} : is_h ? {2{rs2[15:0]}} : rs2;
    if (access && mis) begin
      e.mis = 1'b1; e.rwr = 1'b0; e.chk_wb = 1'b0;
    end else if (access && to_mode) begin
      e.stalls = TO + 1; e.reqs = (gnt_wait >= NEVER) ? TO : gnt_wait + 1;
      e.rwr = 1'b0; e.berr = 1'b1; e.chk_wb = 1'b0; e.chk_bus = 1'b1;
    end else if (access) begin
      e.chk_bus = 1'b1;
      e.reqs    = gnt_wait + 1;
      e.stalls  = 1 + gnt_wait + 1 + (is_load ? rv_lat : 0);
      if (is_load) e.wb = ld_model(rdata_val, alu[1:0], op);
    end

    @(negedge clk);
    pc_plus4_i = pc; alu_result_i = alu; rs2_i = rs2; data_dest_i = dest;
    lsu_op_i = op; reg_wr_sig_i = rwr; mem_wr_sig_i = mwr; reg_wr_addr_i = e.rd;
    sb.push_back(e);

    st = 0; reqs = 0; mis_seen = 1'b0; bus_cap = 1'b0;
    cap_we = 1'b0; cap_addr = 32'h0; cap_wdata = 32'h0; cap_be = 4'h0;
    #1;
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (misaligned_o) mis_seen = 1'b1;
      if (dmem_if.dmem_req_o) begin
        reqs++;
        if (!bus_cap) begin
          bus_cap = 1'b1; cap_we = dmem_if.dmem_we_o; cap_addr = dmem_if.dmem_addr_o;
          cap_be = dmem_if.dmem_be_o; cap_wdata = dmem_if.dmem_wdata_o;
        end
      end
      if (!stall_o) break;
      st++;
      @(negedge clk); #1;
    end

    got = sb.pop_front();
    chk({tag, "/stall_released"}, 32'(stall_o), 32'(0));
    chk({tag, "/stall_cycles"}, st, got.stalls);
    chk({tag, "/req_cycles"}, reqs, got.reqs);
    chk({tag, "/misaligned"}, 32'(mis_seen), 32'(got.mis));
    chk({tag, "/bus_err"}, 32'(bus_err_o), 32'(got.berr));
    chk({tag, "/reg_wr_sig"}, 32'(reg_wr_sig_o), 32'(got.rwr));
    chk({tag, "/reg_wr_addr"}, 32'(reg_wr_addr_o), 32'(got.rd));
    chk({tag, "/req_low_at_end"}, 32'(dmem_if.dmem_req_o), 32'(0));
    if (got.chk_wb) chk({tag, "/wb_data"}, wb_data_o, got.wb);
    if (got.chk_bus) begin
      chk({tag, "/bus_addr"}, cap_addr, got.addr);
      chk({tag, "/bus_we"}, 32'(cap_we), 32'(got.we));
      if (got.we) begin
        chk({tag, "/bus_be"}, 32'(cap_be), 32'(got.be));
        chk({tag, "/bus_wdata"}, cap_wdata, got.wdata);
      end
    end
  endtask

  task automatic nop_inputs();
    pc_plus4_i = 32'h0; alu_result_i = 32'h0; rs2_i = 32'h0; data_dest_i = 2'b00;
    lsu_op_i = 3'b000; reg_wr_sig_i = 1'b0; mem_wr_sig_i = 1'b0; reg_wr_addr_i = 5'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with an aligned store presented: stall must still be held low.
    mem_wr_sig_i = 1'b1; lsu_op_i = 3'b010; alu_result_i = 32'h0000_0040;
    repeat (2) @(negedge clk);
    #1;
    chk("reset/req", 32'(dmem_if.dmem_req_o), 32'(0));
    chk("reset/we", 32'(dmem_if.dmem_we_o), 32'(0));
    chk("reset/addr", dmem_if.dmem_addr_o, RADDR);
    chk("reset/be", 32'(dmem_if.dmem_be_o), 32'(0));
    chk("reset/wdata", dmem_if.dmem_wdata_o, 32'h0);
    chk("reset/stall", 32'(stall_o), 32'(0));
    chk("reset/misaligned", 32'(misaligned_o), 32'(0));
    chk("reset/bus_err", 32'(bus_err_o), 32'(0));
    nop_inputs();
    @(negedge clk); #3 reset = 1'b0;

    gnt_wait = 0; rv_lat = 1;
    step("alu",      32'h0000_0044, 32'h0000_1234, 32'h0, 2'b00, 3'b010, 1'b1, 1'b0);
    step("pc4",      32'h0000_0088, 32'h0000_5555, 32'h0, 2'b10, 3'b010, 1'b1, 1'b0);
    step("sb_103",   32'h0,         32'h0000_0103, 32'hAABB_CCDD, 2'b00, 3'b000, 1'b0, 1'b1);
    step("sh_102",   32'h0,         32'h0000_0102, 32'h1122_3344, 2'b00, 3'b001, 1'b0, 1'b1);
    gnt_wait = 2;
    step("sw_wait2", 32'h0,         32'h0000_0200, 32'hDEAD_BEEF, 2'b00, 3'b010, 1'b0, 1'b1);
    gnt_wait = 0; rdata_val = 32'h0000_8000;
    step("lb_101",   32'h0,         32'h0000_0101, 32'h0, 2'b01, 3'b000, 1'b1, 1'b0);
    step("lbu_101",  32'h0,         32'h0000_0101, 32'h0, 2'b01, 3'b100, 1'b1, 1'b0);
    rdata_val = 32'hBEEF_0000;
    step("lhu_102",  32'h0,         32'h0000_0102, 32'h0, 2'b01, 3'b101, 1'b1, 1'b0);
    rv_lat = 0;
    step("lh_same",  32'h0,         32'h0000_0102, 32'h0, 2'b01, 3'b001, 1'b1, 1'b0);
    gnt_wait = 1; rv_lat = 3; rdata_val = 32'h1234_5678;
    step("lw_slow",  32'h0,         32'h0000_0104, 32'h0, 2'b01, 3'b010, 1'b1, 1'b0);
    gnt_wait = 0; rv_lat = 1; rdata_val = 32'h8765_4321;
    step("lw_op011", 32'h0,         32'h0000_0108, 32'h0, 2'b01, 3'b011, 1'b1, 1'b0);
    step("lw_mis",   32'h0,         32'h0000_0102, 32'h0, 2'b01, 3'b010, 1'b1, 1'b0);
    step("sh_mis",   32'h0,         32'h0000_0101, 32'h1, 2'b00, 3'b001, 1'b0, 1'b1);
    gnt_wait = NEVER;
    step("lw_to_gnt",  32'h0,       32'h0000_0300, 32'h0, 2'b01, 3'b010, 1'b1, 1'b0);
    gnt_wait = 0; rv_lat = NEVER;
    step("lw_to_resp", 32'h0,       32'h0000_0304, 32'h0, 2'b01, 3'b010, 1'b1, 1'b0);
    step("after_to",   32'h0000_0010, 32'h0000_00AB, 32'h0, 2'b00, 3'b010, 1'b1, 1'b0);

    // Reset while a load waits in RESP, then a fresh load completes.
    @(negedge clk);
    data_dest_i = 2'b01; lsu_op_i = 3'b010; alu_result_i = 32'h0000_0400;
    mem_wr_sig_i = 1'b0; reg_wr_sig_i = 1'b1;
    #1 chk("rst_resp/stall_idle", 32'(stall_o), 32'(1));
    @(negedge clk); #1;
    chk("rst_resp/req_in_req", 32'(dmem_if.dmem_req_o), 32'(1));
    @(negedge clk); #1;
    chk("rst_resp/stall_in_resp", 32'(stall_o), 32'(1));
    reset = 1'b1;
    #1;
    chk("rst_resp/stall_async", 32'(stall_o), 32'(0));
    chk("rst_resp/req_async", 32'(dmem_if.dmem_req_o), 32'(0));
    chk("rst_resp/addr_async", dmem_if.dmem_addr_o, RADDR);
    nop_inputs();
    @(negedge clk); #3 reset = 1'b0;
    rv_lat = 1; rdata_val = 32'h1122_3344;
    step("lw_post_rst", 32'h0, 32'h0000_0200, 32'h0, 2'b01, 3'b010, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
